// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM states,
// the EX/MEM entry layout and byte-lane helpers.
package mem_access_pkg;

    // Load size codes (funct3)
    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    // Store size codes (funct3)
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    // EX/MEM pipeline entry
    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic        we;
        logic        re;
        logic        misalign;  // memory op that will be suppressed
    } exm_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes always fit.
    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~lo[0];
            default: is_aligned = (lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        case (size[1:0])
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate store data into every lane so the byte enables pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] d);
        case (size[1:0])
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: picks the addressed lane out of the bus word and
// sign- or zero-extends it according to the load size.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select followed by extension
    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            INST_LB:  data = {{24{lane_b[7]}}, lane_b};
            INST_LBU: data = {24'd0, lane_b};
            INST_LH:  data = {{16{lane_h[15]}}, lane_h};
            INST_LHU: data = {16'd0, lane_h};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I MEM stage: EX/MEM register, data-bus master with timeout and
// misalignment abort, load alignment, MEM/WB register and forwarding taps.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [2:0]  mem_size_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_be_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        hold_o,
    output logic [4:0]  fwd_rd_addr_o,
    output logic [31:0] fwd_rd_data_o,
    output logic        fwd_rd_wen_o,
    output logic        fwd_is_load_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e     state;
    logic [CW-1:0]  wait_cnt;
    exm_t           exm;
    exm_t           ex_in;
    logic           ex_start;
    logic           cnt_last;
    logic [31:0]    load_data;

    // Next EX/MEM entry; a flush turns it into a bubble. The bus transfer is
    // launched on the same edge the entry is captured, so the request is up
    // in the first cycle the entry sits in EX/MEM.
    always_comb begin
        ex_in.rd_addr  = rd_addr_i;
        ex_in.rd_data  = rd_data_i;
        ex_in.rd_wen   = rd_wen_i & ~flush_i;
        ex_in.addr     = mem_addr_i;
        ex_in.data     = mem_data_i;
        ex_in.size     = mem_size_i;
        ex_in.we       = mem_we_i & ~flush_i;
        ex_in.re       = mem_re_i & ~flush_i;
        ex_in.misalign = (ex_in.we | ex_in.re) & ~is_aligned(mem_size_i, mem_addr_i[1:0]);
        ex_start       = (ex_in.we | ex_in.re) & ~ex_in.misalign;
    end

    assign hold_o   = (state == MEM_ACCESS) & ~dbus_ack_i;
    assign cnt_last = (wait_cnt == CNT_LAST);

    // EX/MEM capture, frozen while a transfer is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       exm <= '0;
        else if (!hold_o) exm <= ex_in;
    end

    // Bus FSM: back-to-back accesses re-enter ACCESS straight from the ack edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (ex_start) begin
                        state    <= MEM_ACCESS;
                        wait_cnt <= '0;
                    end
                end
                MEM_ACCESS: begin
                    if (dbus_ack_i) begin
                        state    <= ex_start ? MEM_ACCESS : MEM_IDLE;
                        wait_cnt <= '0;
                    end else if (cnt_last) begin
                        state    <= MEM_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    mem_access_load_align u_load_align (
        .rdata   (dbus_rdata_i),
        .addr_lo (exm.addr[1:0]),
        .size    (exm.size),
        .data    (load_data)
    );

    // MEM/WB: memory ops retire on ack, everything else one edge after
    // capture; a memory op still sitting in EX/MEM while IDLE was already
    // aborted or suppressed and retires as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
            rd_wen_o   <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (state == MEM_ACCESS) begin
                if (dbus_ack_i) begin
                    rd_addr_o <= exm.rd_addr;
                    rd_data_o <= load_data;
                    rd_wen_o  <= exm.re & exm.rd_wen & (exm.rd_addr != 5'd0);
                end else begin
                    rd_wen_o  <= 1'b0;
                    bus_err_o <= cnt_last;
                end
            end else begin
                rd_addr_o  <= exm.rd_addr;
                rd_data_o  <= exm.rd_data;
                rd_wen_o   <= exm.rd_wen & ~exm.we & ~exm.re & (exm.rd_addr != 5'd0);
                misalign_o <= exm.misalign;
            end
        end
    end

    assign dbus_req_o    = (state == MEM_ACCESS);
    assign dbus_we_o     = exm.we;
    assign dbus_addr_o   = {exm.addr[31:2], 2'b00};
    assign dbus_wdata_o  = store_data(exm.size, exm.data);
    assign dbus_be_o     = byte_en(exm.size, exm.addr[1:0]);

    assign fwd_rd_addr_o = exm.rd_addr;
    assign fwd_rd_data_o = exm.rd_data;
    assign fwd_rd_wen_o  = exm.rd_wen & ~exm.we & (exm.rd_addr != 5'd0);
    assign fwd_is_load_o = exm.re;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the MEM stage: ALU pass-through, loads/stores with
// and without wait states, misalignment, timeout, flush and async reset.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [2:0]  mem_size_i;
    logic        mem_we_i;
    logic        mem_re_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        hold_o;
    logic [4:0]  fwd_rd_addr_o;
    logic [31:0] fwd_rd_data_o;
    logic        fwd_rd_wen_o;
    logic        fwd_is_load_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        misalign_o;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_size_i(mem_size_i),
        .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .hold_o(hold_o),
        .fwd_rd_addr_o(fwd_rd_addr_o), .fwd_rd_data_o(fwd_rd_data_o),
        .fwd_rd_wen_o(fwd_rd_wen_o), .fwd_is_load_o(fwd_is_load_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        flush_i = 0; rd_addr_i = 0; rd_data_i = 0; rd_wen_i = 0;
        mem_addr_i = 0; mem_data_i = 0; mem_size_i = 0; mem_we_i = 0; mem_re_i = 0;
    endtask

    task automatic ex(input logic [4:0] rd, input logic [31:0] d, input logic w,
                      input logic [31:0] a, input logic [31:0] sd, input logic [2:0] sz,
                      input logic we, input logic re);
        flush_i = 0; rd_addr_i = rd; rd_data_i = d; rd_wen_i = w;
        mem_addr_i = a; mem_data_i = sd; mem_size_i = sz; mem_we_i = we; mem_re_i = re;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; dbus_ack_i = 0; dbus_rdata_i = 0;
        nop();
        tick();
        chk("rst_req",    32'(dbus_req_o), 32'd0);
        chk("rst_hold",   32'(hold_o),     32'd0);
        chk("rst_wen",    32'(rd_wen_o),   32'd0);
        chk("rst_data",   rd_data_o,       32'd0);
        chk("rst_err",    32'({misalign_o, bus_err_o}), 32'd0);
        rst_n = 1;

        // ALU result pass-through
        ex(5'd5, 32'h1234, 1, 0, 0, 0, 0, 0);
        tick();
        chk("add_hold",   32'(hold_o),        32'd0);
        chk("add_fwd",    32'(fwd_rd_addr_o), 32'd5);
        chk("add_fwdwen", 32'(fwd_rd_wen_o),  32'd1);
        nop();
        tick();
        chk("add_wen",    32'(rd_wen_o),  32'd1);
        chk("add_addr",   32'(rd_addr_o), 32'd5);
        chk("add_data",   rd_data_o,      32'h1234);

        // LB zero-wait, sign extended
        ex(5'd6, 0, 1, 32'h103, 0, INST_LB, 0, 1);
        tick();
        chk("lb_req",     32'(dbus_req_o),    32'd1);
        chk("lb_be",      32'(dbus_be_o),     32'h8);
        chk("lb_addr",    dbus_addr_o,        32'h100);
        chk("lb_we",      32'(dbus_we_o),     32'd0);
        chk("lb_isload",  32'(fwd_is_load_o), 32'd1);
        nop(); dbus_ack_i = 1; dbus_rdata_i = 32'h80FFFFFF;
        #1 chk("lb_hold", 32'(hold_o), 32'd0);
        tick(); dbus_ack_i = 0;
        chk("lb_wen",     32'(rd_wen_o),   32'd1);
        chk("lb_data",    rd_data_o,       32'hFFFFFF80);
        chk("lb_rd",      32'(rd_addr_o),  32'd6);
        chk("lb_reqdn",   32'(dbus_req_o), 32'd0);

        // LBU zero extended
        ex(5'd6, 0, 1, 32'h103, 0, INST_LBU, 0, 1);
        tick();
        nop(); dbus_ack_i = 1;
        tick(); dbus_ack_i = 0;
        chk("lbu_data",   rd_data_o, 32'h00000080);

        // SH with 3 wait cycles; next instruction waits in EX meanwhile
        ex(5'd0, 0, 0, 32'h102, 32'hABCD, INST_SH, 1, 0);
        tick();
        chk("sh_we",      32'(dbus_we_o),  32'd1);
        chk("sh_be",      32'(dbus_be_o),  32'hC);
        chk("sh_wdata",   dbus_wdata_o,    32'hABCDABCD);
        ex(5'd7, 32'h77, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sh_hold", 32'(hold_o),   32'd1);
            chk("sh_wen0", 32'(rd_wen_o), 32'd0);
            tick();
        end
        dbus_ack_i = 1;
        #1 chk("sh_ackhold", 32'(hold_o), 32'd0);
        chk("sh_bestable", 32'(dbus_be_o), 32'hC);
        tick(); dbus_ack_i = 0;
        chk("sh_wen",     32'(rd_wen_o),   32'd0);
        chk("sh_reqdn",   32'(dbus_req_o), 32'd0);
        nop();
        tick();
        chk("sh_next",    {27'd0, rd_wen_o, rd_addr_o} , {27'd0, 1'b1, 5'd7});
        chk("sh_nextd",   rd_data_o, 32'h77);

        // Misaligned LW is suppressed
        ex(5'd8, 0, 1, 32'h101, 0, INST_LW, 0, 1);
        tick();
        chk("mis_req",    32'(dbus_req_o), 32'd0);
        chk("mis_hold",   32'(hold_o),     32'd0);
        ex(5'd9, 32'h99, 1, 0, 0, 0, 0, 0);
        tick();
        chk("mis_pulse",  32'(misalign_o), 32'd1);
        chk("mis_wen",    32'(rd_wen_o),   32'd0);
        nop();
        tick();
        chk("mis_end",    32'(misalign_o), 32'd0);
        chk("mis_next",   rd_data_o,       32'h99);
        chk("mis_nwen",   32'(rd_wen_o),   32'd1);

        // LW timeout: 16 request cycles then abort
        ex(5'd10, 0, 1, 32'h200, 0, INST_LW, 0, 1);
        tick();
        nop();
        chk("to_req1",    32'(dbus_req_o), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_req",  32'({dbus_req_o, hold_o, bus_err_o}), 32'b110);
        end
        tick();
        chk("to_err",     32'(bus_err_o),  32'd1);
        chk("to_req0",    32'(dbus_req_o), 32'd0);
        chk("to_hold0",   32'(hold_o),     32'd0);
        chk("to_wen",     32'(rd_wen_o),   32'd0);
        tick();
        chk("to_errend",  32'(bus_err_o),  32'd0);
        chk("to_wen2",    32'(rd_wen_o),   32'd0);

        // Ack in the 16th cycle wins over timeout
        ex(5'd11, 0, 1, 32'h204, 0, INST_LW, 0, 1);
        tick();
        nop();
        for (int i = 1; i < 16; i++) tick();
        chk("lt_req",     32'(dbus_req_o), 32'd1);
        dbus_ack_i = 1; dbus_rdata_i = 32'h11223344;
        tick(); dbus_ack_i = 0;
        chk("lt_wen",     32'(rd_wen_o),  32'd1);
        chk("lt_data",    rd_data_o,      32'h11223344);
        chk("lt_err",     32'(bus_err_o), 32'd0);

        // Flush while stalled is ignored; LHU still completes
        ex(5'd12, 0, 1, 32'h106, 0, INST_LHU, 0, 1);
        tick();
        ex(5'd13, 32'h55, 1, 0, 0, 0, 0, 0); flush_i = 1;
        tick();
        chk("fl_req",     32'(dbus_req_o),    32'd1);
        chk("fl_frozen",  32'(fwd_rd_addr_o), 32'd12);
        nop(); dbus_ack_i = 1; dbus_rdata_i = 32'hBEEF0000;
        tick(); dbus_ack_i = 0;
        chk("fl_wen",     32'(rd_wen_o),  32'd1);
        chk("fl_data",    rd_data_o,      32'h0000BEEF);
        chk("fl_rd",      32'(rd_addr_o), 32'd12);

        // LH sign extended from upper half
        ex(5'd13, 0, 1, 32'h102, 0, INST_LH, 0, 1);
        tick();
        chk("lh_be",      32'(dbus_be_o), 32'hC);
        nop(); dbus_ack_i = 1; dbus_rdata_i = 32'h80010000;
        tick(); dbus_ack_i = 0;
        chk("lh_data",    rd_data_o, 32'hFFFF8001);

        // SB / SW zero-wait
        ex(5'd0, 0, 0, 32'h101, 32'h5A, INST_SB, 1, 0);
        tick();
        chk("sb_be",      32'(dbus_be_o), 32'h2);
        chk("sb_wdata",   dbus_wdata_o,   32'h5A5A5A5A);
        ex(5'd0, 0, 0, 32'h8, 32'hCAFEF00D, INST_SW, 1, 0); dbus_ack_i = 1;
        tick();
        chk("sw_req",     32'(dbus_req_o), 32'd1);
        chk("sw_be",      32'(dbus_be_o),  32'hF);
        chk("sw_wdata",   dbus_wdata_o,    32'hCAFEF00D);
        chk("sw_addr",    dbus_addr_o,     32'h8);
        chk("sb_wen",     32'(rd_wen_o),   32'd0);
        nop();
        tick(); dbus_ack_i = 0;
        chk("sw_wen",     32'(rd_wen_o),   32'd0);

        // rd=0 never writes
        ex(5'd0, 32'hDEAD, 1, 0, 0, 0, 0, 0);
        tick();
        chk("x0_fwd",     32'(fwd_rd_wen_o), 32'd0);
        nop();
        tick();
        chk("x0_wen",     32'(rd_wen_o), 32'd0);

        // Async reset mid-access
        ex(5'd14, 0, 1, 32'h300, 0, INST_LW, 0, 1);
        tick();
        nop();
        chk("ra_req",     32'(dbus_req_o), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("ra_req0",    32'(dbus_req_o), 32'd0);
        chk("ra_hold0",   32'(hold_o),     32'd0);
        #2 rst_n = 1;
        tick();
        chk("ra_idle",    32'(dbus_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
